mem_arbiter: RTL and testbench

- Arbitrates single-word RAM access between the icache miss path and the dcache, one transaction at a time.
- Sits directly downstream of the icache, on the cache-control side.
- Latches a grant, holds RAM controls stable until the RAM reports completion, then releases the requester's wait for exactly one cycle.
- Adds a per-transaction timeout with a sticky error flag.

---
 rtl/aww_types_pkg.sv | 16 +
 rtl/cpu_types_pkg.sv | 11 +
 rtl/arb_timeout.sv | 22 ++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/aww_types_pkg.sv
// Arbiter types: FSM states, grant owner and counter limits.
package aww_types_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } arb_owner_t;

  localparam int ARB_TIMEOUT_MAX = 1023;
  localparam int ARB_CNT_W       = 10;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the RAM word and the RAM status encoding.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

// File: rtl/arb_timeout.sv
// Saturating grant-age counter; expired is high once count reaches LIMIT.
module arb_timeout #(
  parameter int LIMIT = 255,
  parameter int W     = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         expired
);
  assign expired = (count == W'(LIMIT));

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + W'(1);
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-word RAM arbiter between the icache miss path and the dcache.
// Define ARB_ROUNDROBIN_EN to alternate the winner on simultaneous requests.
module mem_arbiter
  import cpu_types_pkg::*;
  import aww_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 iREN,
  input  word_t                iaddr,
  output logic                 iwait,
  output word_t                iload,
  input  logic                 dREN,
  input  logic                 dWEN,
  input  word_t                daddr,
  input  word_t                dstore,
  output logic                 dwait,
  output word_t                dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output word_t                ramaddr,
  output word_t                ramstore,
  input  word_t                ramload,
  input  ramstate_t            ramstate,
  output logic                 err,
  output arb_state_t           dbg_state,
  output logic [ARB_CNT_W-1:0] dbg_count
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t    state;
  logic [CW-1:0] count;
  logic          expired;
  logic          dreq;
  logic          granted;
  logic          fault;
  logic          complete;
  logic          pick_d;

  assign dreq     = dREN | dWEN;
  assign fault    = (ramstate == ERROR) | expired;
  assign complete = (state != IDLE) & ((ramstate == ACCESS) | fault);
  assign granted  = (state == IGRANT) ? iREN : dreq;

  // Waits stay high for any request while reset is held.
  assign iwait = iREN & ~(~RST & (state == IGRANT) & complete);
  assign dwait = dreq & ~(~RST & (state == DGRANT) & complete);

  assign iload     = ramload;
  assign dload     = ramload;
  assign dbg_state = state;
  assign dbg_count = ARB_CNT_W'(count);

`ifdef ARB_ROUNDROBIN_EN
  arb_owner_t last_grant;

  // Withdrawals leave the history untouched; only completed grants count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_grant <= INSTR;
    end else if (complete) begin
      last_grant <= (state == DGRANT) ? DATA : INSTR;
    end
  end

  assign pick_d = dreq & (~iREN | (last_grant == INSTR));
`else
  assign pick_d = dreq;
`endif

  arb_timeout #(
    .LIMIT(TIMEOUT_CYCLES),
    .W    (CW)
  ) u_timeout (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (state == IDLE),
    .en     ((state != IDLE) & ~complete),
    .count  (count),
    .expired(expired)
  );

  // RAM controls are latched on grant entry so they stay stable until exit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      err      <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
    end else begin
      err <= err | (complete & fault);
      case (state)
        IDLE: begin
          if (pick_d) begin
            state    <= DGRANT;
            ramREN   <= ~dWEN;
            ramWEN   <= dWEN;
            ramaddr  <= daddr;
            ramstore <= dWEN ? dstore : '0;
          end else if (iREN) begin
            state   <= IGRANT;
            ramREN  <= 1'b1;
            ramaddr <= iaddr;
          end
        end
        default: begin
          if (complete || !granted) begin
            state    <= IDLE;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle table, then randomized traffic vs a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import cpu_types_pkg::*;
  import aww_types_pkg::*;

  localparam int TO = 4;
  localparam int OW = 135;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam word_t Z = 32'h0;

  logic       CLK = 1'b0;
  logic       RST, iREN, dREN, dWEN;
  word_t      iaddr, daddr, dstore, ramload;
  ramstate_t  ramstate;
  logic       iwait, dwait, ramREN, ramWEN, err;
  word_t      iload, dload, ramaddr, ramstore;
  arb_state_t dbg_state;
  logic [9:0] dbg_count;

  int errors = 0;
  int checks = 0;
  logic [OW-1:0] exp_q[$];

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err),
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  // clock
  always #5 CLK = ~CLK;

  typedef struct {
    logic rst, ir, dr, dw;
    word_t ia, da, ds;
    ramstate_t rs;
    word_t rl;
    logic xiw, xdw, xren, xwen, xerr;
    word_t xaddr, xstore;
    arb_state_t xst;
    int xcnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [OW-1:0] pack(logic iw, logic dw, logic ren, logic wen, logic e,
                                         word_t a, word_t s, word_t il, word_t dl, arb_state_t st);
    return {iw, dw, ren, wen, e, a, s, il, dl, st};
  endfunction

  task automatic drive(input logic r, input logic ir, input logic dr, input logic dw,
                       input word_t ia, input word_t da, input word_t ds,
                       input ramstate_t rs, input word_t rl);
    RST = r; iREN = ir; dREN = dr; dWEN = dw;
    iaddr = ia; daddr = da; dstore = ds; ramstate = rs; ramload = rl;
  endtask

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] actual();
    return pack(iwait, dwait, ramREN, ramWEN, err, ramaddr, ramstore, iload, dload, dbg_state);
  endfunction

  // Transaction-level reference: who owns the RAM, how long, what was latched.
  int    m_owner;  // 0 none, 1 instruction, 2 data
  int    m_age;
  int    m_last;   // 1 instruction, 2 data
  logic  m_we, m_err;
  word_t m_addr, m_store;

  function automatic logic [OW-1:0] model_out();
    logic done, dq;
    arb_state_t st;
    dq   = dREN | dWEN;
    done = (m_owner != 0) && (ramstate == ACCESS || ramstate == ERROR || m_age == TO);
    st   = (m_owner == 1) ? IGRANT : (m_owner == 2) ? DGRANT : IDLE;
    return pack(iREN & ~(~RST & (m_owner == 1) & done),
                dq & ~(~RST & (m_owner == 2) & done),
                (m_owner == 1) || (m_owner == 2 && !m_we),
                (m_owner == 2) && m_we,
                m_err,
                (m_owner != 0) ? m_addr : Z,
                (m_owner == 2 && m_we) ? m_store : Z,
                ramload, ramload, st);
  endfunction

  task automatic model_step();
    logic done, held, take_d;
    if (RST) begin
      m_owner = 0; m_age = 0; m_err = 1'b0; m_last = 1; m_we = 1'b0;
    end else if (m_owner == 0) begin
`ifdef ARB_ROUNDROBIN_EN
      take_d = (dREN | dWEN) && (!iREN || m_last == 1);
`else
      take_d = dREN | dWEN;
`endif
      if (take_d) begin
        m_owner = 2; m_we = dWEN; m_addr = daddr; m_store = dWEN ? dstore : Z; m_age = 0;
      end else if (iREN) begin
        m_owner = 1; m_we = 1'b0; m_addr = iaddr; m_store = Z; m_age = 0;
      end
    end else begin
      done = (ramstate == ACCESS || ramstate == ERROR || m_age == TO);
      held = (m_owner == 1) ? iREN : (dREN | dWEN);
      if (done) begin
        if (ramstate == ERROR || m_age == TO) m_err = 1'b1;
        m_last = m_owner;
        m_owner = 0;
      end else if (!held) begin
        m_owner = 0;
      end else begin
        m_age++;
      end
    end
  endtask

  initial begin
    vec_t v;
    ramstate_t rs;
    int r;

    // reset
    drive(H, L, L, L, Z, Z, Z, FREE, Z);
    repeat (3) @(posedge CLK);
    #1;

    // rst,ir,dr,dw, ia,da,ds, rs,rl | iw,dw,ren,wen,err, addr,store, state, cnt
    v = '{H,H,H,L, Z,Z,Z, FREE,32'h11, H,H,L,L,L, Z,Z, IDLE,0}; vecs.push_back(v);
    // instruction read, ACCESS on first grant cycle
    v = '{L,H,L,L, 32'h40,Z,Z, FREE,32'hDEADBEEF, H,L,L,L,L, Z,Z, IDLE,-1}; vecs.push_back(v);
    v = '{L,H,L,L, 32'h40,Z,Z, ACCESS,32'hDEADBEEF, L,L,H,L,L, 32'h40,Z, IGRANT,0}; vecs.push_back(v);
    v = '{L,L,L,L, Z,Z,Z, FREE,Z, L,L,L,L,L, Z,Z, IDLE,-1}; vecs.push_back(v);
    // data write, three BUSY then ACCESS
    v = '{L,L,L,H, Z,32'h100,32'h12345678, BUSY,Z, L,H,L,L,L, Z,Z, IDLE,-1}; vecs.push_back(v);
    for (int k = 0; k < 3; k++) begin
      v = '{L,L,L,H, Z,32'h100,32'h12345678, BUSY,32'h5A, L,H,L,H,L, 32'h100,32'h12345678, DGRANT,k};
      vecs.push_back(v);
    end
    v = '{L,L,L,H, Z,32'h100,32'h12345678, ACCESS,32'h77, L,L,L,H,L, 32'h100,32'h12345678, DGRANT,3}; vecs.push_back(v);
    v = '{L,L,L,L, Z,Z,Z, FREE,Z, L,L,L,L,L, Z,Z, IDLE,-1}; vecs.push_back(v);
    // withdrawal in second grant cycle
    v = '{L,H,L,L, 32'h80,Z,Z, BUSY,Z, H,L,L,L,L, Z,Z, IDLE,-1}; vecs.push_back(v);
    v = '{L,H,L,L, 32'h80,Z,Z, BUSY,Z, H,L,H,L,L, 32'h80,Z, IGRANT,0}; vecs.push_back(v);
    v = '{L,L,L,L, 32'h80,Z,Z, BUSY,Z, L,L,H,L,L, 32'h80,Z, IGRANT,1}; vecs.push_back(v);
    v = '{L,L,L,L, Z,Z,Z, FREE,Z, L,L,L,L,L, Z,Z, IDLE,-1}; vecs.push_back(v);
    // timeout with RAM stuck BUSY
    v = '{L,L,H,L, Z,32'h200,Z, BUSY,Z, L,H,L,L,L, Z,Z, IDLE,-1}; vecs.push_back(v);
    for (int k = 0; k < 4; k++) begin
      v = '{L,L,H,L, Z,32'h200,Z, BUSY,Z, L,H,H,L,L, 32'h200,Z, DGRANT,k}; vecs.push_back(v);
    end
    v = '{L,L,H,L, Z,32'h200,Z, BUSY,Z, L,L,H,L,L, 32'h200,Z, DGRANT,4}; vecs.push_back(v);
    v = '{L,L,L,L, Z,Z,Z, FREE,Z, L,L,L,L,H, Z,Z, IDLE,-1}; vecs.push_back(v);
    // later good transaction keeps err
    v = '{L,H,L,L, 32'h44,Z,Z, FREE,Z, H,L,L,L,H, Z,Z, IDLE,-1}; vecs.push_back(v);
    v = '{L,H,L,L, 32'h44,Z,Z, ACCESS,32'hCAFE, L,L,H,L,H, 32'h44,Z, IGRANT,0}; vecs.push_back(v);
    v = '{L,L,L,L, Z,Z,Z, FREE,Z, L,L,L,L,H, Z,Z, IDLE,-1}; vecs.push_back(v);
    // reset during a data grant
    v = '{L,L,H,L, Z,32'h300,Z, BUSY,Z, L,H,L,L,H, Z,Z, IDLE,-1}; vecs.push_back(v);
    v = '{L,L,H,L, Z,32'h300,Z, BUSY,Z, L,H,H,L,H, 32'h300,Z, DGRANT,0}; vecs.push_back(v);
    v = '{H,L,H,L, Z,32'h300,Z, ACCESS,Z, L,H,H,L,H, 32'h300,Z, DGRANT,1}; vecs.push_back(v);
    v = '{L,L,L,L, Z,Z,Z, FREE,Z, L,L,L,L,L, Z,Z, IDLE,0}; vecs.push_back(v);
    // simultaneous requests, twice
    v = '{L,H,H,L, 32'h500,32'h600,Z, FREE,Z, H,H,L,L,L, Z,Z, IDLE,-1}; vecs.push_back(v);
    v = '{L,H,H,L, 32'h500,32'h600,Z, ACCESS,Z, H,L,H,L,L, 32'h600,Z, DGRANT,0}; vecs.push_back(v);
    v = '{L,L,L,L, Z,Z,Z, FREE,Z, L,L,L,L,L, Z,Z, IDLE,-1}; vecs.push_back(v);
    v = '{L,H,H,L, 32'h500,32'h600,Z, FREE,Z, H,H,L,L,L, Z,Z, IDLE,-1}; vecs.push_back(v);
`ifdef ARB_ROUNDROBIN_EN
    v = '{L,H,H,L, 32'h500,32'h600,Z, ACCESS,Z, L,H,H,L,L, 32'h500,Z, IGRANT,0}; vecs.push_back(v);
`else
    v = '{L,H,H,L, 32'h500,32'h600,Z, ACCESS,Z, H,L,H,L,L, 32'h600,Z, DGRANT,0}; vecs.push_back(v);
`endif
    v = '{L,L,L,L, Z,Z,Z, FREE,Z, L,L,L,L,L, Z,Z, IDLE,-1}; vecs.push_back(v);
    // RAM ERROR completes a write and sets err
    v = '{L,L,L,H, Z,32'h700,32'hAA, FREE,Z, L,H,L,L,L, Z,Z, IDLE,-1}; vecs.push_back(v);
    v = '{L,L,L,H, Z,32'h700,32'hAA, ERROR,Z, L,L,L,H,L, 32'h700,32'hAA, DGRANT,0}; vecs.push_back(v);
    v = '{L,L,L,L, Z,Z,Z, FREE,Z, L,L,L,L,H, Z,Z, IDLE,-1}; vecs.push_back(v);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].ir, vecs[i].dr, vecs[i].dw, vecs[i].ia, vecs[i].da,
            vecs[i].ds, vecs[i].rs, vecs[i].rl);
      @(negedge CLK);
      check($sformatf("vec%0d", i), actual(),
            pack(vecs[i].xiw, vecs[i].xdw, vecs[i].xren, vecs[i].xwen, vecs[i].xerr,
                 vecs[i].xaddr, vecs[i].xstore, vecs[i].rl, vecs[i].rl, vecs[i].xst));
      if (vecs[i].xcnt >= 0)
        check($sformatf("vec%0d_cnt", i), OW'(dbg_count), OW'(vecs[i].xcnt));
      @(posedge CLK);
      #1;
    end

    // randomized traffic; the first cycle resets to align the model
    drive(H, L, L, L, Z, Z, Z, FREE, Z);
    @(posedge CLK);
    model_step();
    #1;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 9);
      rs = (r < 2) ? FREE : (r < 7) ? BUSY : (r < 9) ? ACCESS : ERROR;
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
            $urandom, $urandom, $urandom, rs, $urandom);
      exp_q.push_back(model_out());
      @(negedge CLK);
      check($sformatf("rand%0d", c), actual(), exp_q.pop_front());
      @(posedge CLK);
      model_step();
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
